// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, sequencer state encoding and flag bit positions.
// Used by the ALU decoder and the sequential execute unit alike.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between an issuing stage and alu_seq_exec.
// Master issues start/opcode/operands; slave returns status and registered results.
interface alu_seq_exec_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic [3:0]       flags;
    logic             div_zero;

    modport master (
        output start, ALUControl, a, b,
        input  busy, done, result, remainder, flags, div_zero
    );

    modport slave (
        input  start, ALUControl, a, b,
        output busy, done, result, remainder, flags, div_zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per step.
// Latency: WIDTH steps after load; last_o flags the final step; no backpressure.
module alu_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             last_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_trial;

    // Mul: {hi,lo} shifts right with the partial sum entering at the top.
    // Div: {hi,lo} shifts left; hi is the partial remainder, lo collects quotient bits.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_trial = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, opnd_q};

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        if (load_i) begin
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = is_div_i ? a_i : b_i;
            opnd_d   = is_div_i ? b_i : a_i;
            is_div_d = is_div_i;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
                if (div_trial[WIDTH+1]) begin
                    hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end else begin
                    hi_d = div_trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
        end
    end

    assign lo_o   = lo_q;
    assign hi_o   = hi_q;
    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU: add/sub/NOP in one cycle, mul/div iterated over WIDTH cycles.
// Latency: done 1 cycle after accept (add/sub/NOP/div-by-zero), WIDTH+1 for mul/div.
// Backpressure: start is only accepted while idle; requests while busy are dropped.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_exec_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    alu_state_e       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [3:0]       flags_q, flags_d;
    logic             div_zero_q, div_zero_d;
    logic             done_q;

    logic             accept, step, finish, last;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH:0]   add_w, sub_w;
    logic             c_d, v_d;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .step_i   (step),
        .is_div_i (bus.ALUControl == ALU_DIV),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .lo_o     (md_lo),
        .hi_o     (md_hi),
        .last_o   (last)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    op_d   = bus.ALUControl;
                    a_d    = bus.a;
                    b_d    = bus.b;
                    if (bus.ALUControl == ALU_MUL ||
                        (bus.ALUControl == ALU_DIV && bus.b != '0)) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign add_w = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        result_d   = '0;
        rem_d      = '0;
        c_d        = 1'b0;
        v_d        = 1'b0;
        div_zero_d = 1'b0;
        case (op_q)
            ALU_ADD: begin
                result_d = add_w[MSB:0];
                c_d      = add_w[WIDTH];
                v_d      = (a_q[MSB] == b_q[MSB]) && (add_w[MSB] != a_q[MSB]);
            end
            ALU_SUB: begin
                result_d = sub_w[MSB:0];
                c_d      = ~sub_w[WIDTH];
                v_d      = (a_q[MSB] != b_q[MSB]) && (sub_w[MSB] != a_q[MSB]);
            end
            ALU_MUL: begin
                result_d = md_lo;
                c_d      = |md_hi;
            end
            ALU_DIV: begin
                if (b_q == '0) begin
                    result_d   = '1;
                    rem_d      = a_q;
                    div_zero_d = 1'b1;
                end else begin
                    result_d = md_lo;
                    rem_d    = md_hi;
                end
            end
            default: ;
        endcase
        flags_d         = '0;
        flags_d[FLAG_N] = result_d[MSB];
        flags_d[FLAG_Z] = (result_d == '0);
        flags_d[FLAG_C] = c_d;
        flags_d[FLAG_V] = v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            rem_q      <= '0;
            flags_q    <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= finish;
            if (finish) begin
                result_q   <= result_d;
                rem_q      <= rem_d;
                flags_q    <= flags_d;
                div_zero_q <= div_zero_d;
            end
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.remainder = rem_q;
    assign bus.flags     = flags_q;
    assign bus.div_zero  = div_zero_q;

endmodule
